// File: rtl/scarv_uart_rx.sv
// -----------------------------------------------------------------------------
// scarv_uart_rx
//
// UART receiver for an asynchronous 8N1 / 8N2 serial line. The line is
// synchronised into the f_clk domain, each frame is sampled at mid-bit, and
// completed bytes are offered on a valid/ready handshake.
//
// Parameters
//   UART_BIT_RATE   line bit rate in bits/s
//   UART_CLK_HZ     f_clk frequency in Hz
//   UART_STOP_BITS  stop bits per frame (1 or 2)
//
// Ports
//   f_clk         in   single clock, all logic runs in this domain
//   sys_reset     in   asynchronous active-high reset
//   uart_rxd      in   serial input, idle high, asynchronous to f_clk
//   rx_data       out  received byte (LSB first on the line)
//   rx_valid      out  rx_data holds an unconsumed byte
//   rx_ready      in   consumer takes the byte when rx_valid & rx_ready
//   rx_frame_err  out  one-cycle pulse: a stop bit was sampled low
//   rx_overrun    out  one-cycle pulse: a byte completed while the previous
//                      one was still unconsumed (the new byte is dropped)
// -----------------------------------------------------------------------------
module scarv_uart_rx #(
    parameter int UART_BIT_RATE  = 256_000,
    parameter int UART_CLK_HZ    = 50_000_000,
    parameter int UART_STOP_BITS = 1
) (
    input  logic       f_clk,
    input  logic       sys_reset,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam int CPB  = UART_CLK_HZ / UART_BIT_RATE;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB) + 1;

    localparam logic [CW-1:0] CNT_HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_BIT_LAST  = CW'(CPB - 1);
    localparam logic [1:0]    STOP_LAST     = 2'(UART_STOP_BITS - 1);

    generate
        if (CPB < 4) begin : g_bad_cpb
            $error("scarv_uart_rx: clocks per bit must be at least 4");
        end
        if ((UART_STOP_BITS < 1) || (UART_STOP_BITS > 2)) begin : g_bad_stop
            $error("scarv_uart_rx: UART_STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;

    logic            sync_meta_r;
    logic            rxs_r;
    logic [CW-1:0]   cnt_r;
    logic [2:0]      bit_idx_r;
    logic [1:0]      stop_idx_r;
    logic            stop_err_r;
    logic [7:0]      shift_r;

    logic            cnt_clr_s;
    logic            shift_en_s;
    logic            stop_en_s;
    logic            deliver_s;
    logic            ferr_s;
    logic            accept_s;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge f_clk or posedge sys_reset) begin
        if (sys_reset) begin
            sync_meta_r <= 1'b1;
            rxs_r       <= 1'b1;
        end else begin
            sync_meta_r <= uart_rxd;
            rxs_r       <= sync_meta_r;
        end
    end

    // FSM state register.
    always_ff @(posedge f_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state and datapath strobes. Every transition also clears cnt,
    // so each state starts counting from zero.
    always_comb begin
        state_nxt_s = state_r;
        cnt_clr_s   = 1'b0;
        shift_en_s  = 1'b0;
        stop_en_s   = 1'b0;
        deliver_s   = 1'b0;
        ferr_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!rxs_r) begin
                    state_nxt_s = ST_START;
                    cnt_clr_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                // Re-check the start bit at its middle to reject glitches.
                if (cnt_r == CNT_HALF_LAST) begin
                    cnt_clr_s   = 1'b1;
                    state_nxt_s = rxs_r ? ST_IDLE : ST_DATA;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (cnt_r == CNT_BIT_LAST) begin
                    cnt_clr_s  = 1'b1;
                    shift_en_s = 1'b1;
                    if (bit_idx_r == 3'd7) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (cnt_r == CNT_BIT_LAST) begin
                    cnt_clr_s = 1'b1;
                    stop_en_s = 1'b1;
                    if (stop_idx_r == STOP_LAST) begin
                        // Final stop sample: fold in this sample directly
                        // since stop_err_r only updates at the clock edge.
                        if (stop_err_r || !rxs_r) begin
                            ferr_s      = 1'b1;
                            state_nxt_s = ST_WAIT_HIGH;
                        end else begin
                            deliver_s   = 1'b1;
                            state_nxt_s = ST_IDLE;
                        end
                    end else begin
                        state_nxt_s = ST_STOP;
                    end
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            ST_WAIT_HIGH: begin
                // Hold off until the line recovers so a break is not
                // reinterpreted as a stream of zero frames.
                if (rxs_r) begin
                    cnt_clr_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_HIGH;
                end
            end
            default: begin
                cnt_clr_s   = 1'b1;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Bit-period counter, bit/stop indices, stop error flag and shift register.
    always_ff @(posedge f_clk or posedge sys_reset) begin
        if (sys_reset) begin
            cnt_r      <= {CW{1'b0}};
            bit_idx_r  <= 3'd0;
            stop_idx_r <= 2'd0;
            stop_err_r <= 1'b0;
            shift_r    <= 8'h00;
        end else begin
            if (cnt_clr_s) begin
                cnt_r <= {CW{1'b0}};
            end else if ((state_r == ST_START) || (state_r == ST_DATA) ||
                         (state_r == ST_STOP)) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end

            if (state_r == ST_START) begin
                bit_idx_r <= 3'd0;
            end else if (shift_en_s) begin
                bit_idx_r <= bit_idx_r + 3'd1;
            end else begin
                bit_idx_r <= bit_idx_r;
            end

            if (state_r == ST_DATA) begin
                stop_idx_r <= 2'd0;
                stop_err_r <= 1'b0;
            end else if (stop_en_s) begin
                stop_idx_r <= stop_idx_r + 2'd1;
                stop_err_r <= stop_err_r | ~rxs_r;
            end else begin
                stop_idx_r <= stop_idx_r;
                stop_err_r <= stop_err_r;
            end

            // LSB arrives first: shift in at the top, after eight shifts
            // bit 0 sits at the bottom.
            if (shift_en_s) begin
                shift_r <= {rxs_r, shift_r[7:1]};
            end else begin
                shift_r <= shift_r;
            end
        end
    end

    assign accept_s = rx_valid & rx_ready;

    // Output registers: byte hand-off, overrun and frame-error pulses.
    always_ff @(posedge f_clk or posedge sys_reset) begin
        if (sys_reset) begin
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_frame_err <= ferr_s;
            rx_overrun   <= deliver_s & rx_valid & ~rx_ready;
            if (deliver_s && (!rx_valid || rx_ready)) begin
                rx_data  <= shift_r;
                rx_valid <= 1'b1;
            end else if (accept_s) begin
                rx_data  <= rx_data;
                rx_valid <= 1'b0;
            end else begin
                rx_data  <= rx_data;
                rx_valid <= rx_valid;
            end
        end
    end

endmodule

// File: doc/scarv_uart_rx.md
# scarv_uart_rx

UART receiver that deserialises an asynchronous 8N1/8N2 serial line into bytes and presents them on a valid/ready handshake. It is the receiving end of the SoC's `uart_txd` link. It is instanced host-side in FPGA bring-up designs and in the verification environment to capture SoC console output. It shares the baud parameters of the SoC UART, so both ends agree on framing by construction.

## Interface
- `UART_BIT_RATE`, 256_000: line bit rate, bits/s.
- `UART_CLK_HZ`, 50_000_000: `f_clk` frequency, Hz.
- `UART_STOP_BITS`, 1: stop bits per frame (1 or 2).
- Derived: `CPB = UART_CLK_HZ / UART_BIT_RATE` (integer, truncating), `HALF = CPB / 2`. Elaboration must fail if `CPB < 4`.
- `f_clk`  in  1  single clock; all logic in this domain.
- `sys_reset`  in  1  asynchronous, active-high reset.
- `uart_rxd`  in  1  serial input, idle high, asynchronous to `f_clk`.
- `rx_data`  out  8  received byte, LSB first on line.
- `rx_valid`  out  1  `rx_data` holds an unconsumed byte.
- `rx_ready`  in  1  consumer accepts byte when `rx_valid & rx_ready`.
- `rx_frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `rx_overrun`  out  1  one-cycle pulse: byte completed while previous one unconsumed.

## Operation
- `uart_rxd` passes through a 2-flop synchroniser; `rxs` is the synchronised value. All decisions use `rxs`.
- Bit counter `cnt` is cleared on every state entry and increments each cycle in START, DATA and STOP.
- FSM states:
  - IDLE: `rxs==0` -> START.
  - START: at `cnt==HALF-1`, if `rxs==0` -> DATA; else false start -> IDLE.
  - DATA: at `cnt==CPB-1`, shift `rxs` into the shift register LSB-first and clear `cnt`; after the 8th bit -> STOP.
  - STOP: at `cnt==CPB-1`, sample the stop bit and clear `cnt`. Any sampled 0 marks a frame error. After `UART_STOP_BITS` samples: if clean -> deliver, then IDLE; if error -> pulse `rx_frame_err`, discard the byte, then WAIT_HIGH.
  - WAIT_HIGH: stays until `rxs==1`, then -> IDLE. This stops a break condition from generating repeated frames.
- Deliver rules:
  - `rx_valid==0`, or `rx_valid & rx_ready` in the same cycle: load `rx_data`, set `rx_valid`.
  - Otherwise: keep the old byte, drop the new one, pulse `rx_overrun`.
- Handshake:
  - `rx_valid` and `rx_data` stay stable until accepted.
  - On acceptance with no simultaneous delivery, `rx_valid` clears next cycle.
- Reset (any time, including mid-frame):
  - FSM -> IDLE, `cnt=0`, shift register = 0.
  - Synchroniser flops reset to 1 (line idle).
  - Output reset values: `rx_data=8'h00`, `rx_valid=0`, `rx_frame_err=0`, `rx_overrun=0`.
  - A partial frame in progress is lost. After release, the receiver resynchronises on the next falling edge seen in IDLE.

## Timing
- `rxs` lags `uart_rxd` by 2 cycles.
- Let T0 be the first cycle IDLE observes `rxs==0`. START is entered at T0+1.
- Sample points:
  - Start bit: T0+HALF.
  - Data bit i (0..7): T0+HALF+CPB*(i+1).
  - Stop bit j: T0+HALF+CPB*(9+j).
- `rx_valid` (or `rx_frame_err`/`rx_overrun`) asserts at T0+HALF+CPB*(8+UART_STOP_BITS)+1.
- IDLE is re-entered the cycle after the final stop sample. A start bit beginning immediately after the nominal stop-bit end is therefore caught (back-to-back frames).
- Tolerated baud mismatch: about ±4% per frame for CPB ≥ 16.
- All outputs are registered; no combinational path from `rx_ready` to any output.

## Test plan
Bench parameters: `UART_CLK_HZ=1_600_000`, `UART_BIT_RATE=100_000` (CPB=16, HALF=8), `UART_STOP_BITS=1`, `rx_ready=1` unless stated.
- Send 0xA5 -> `rx_valid` pulses once with `rx_data=0xA5`, exactly HALF+CPB*9+1 cycles after T0; no error pulses.
- Back-to-back 0x00 then 0xFF with zero idle gap -> two deliveries, 0x00 then 0xFF, 160 cycles apart.
- `rx_ready=0`, send 0x11 then 0x22 -> `rx_data` stays 0x11, `rx_overrun` pulses once at the second frame end. Raise `rx_ready` -> `rx_valid` clears next cycle.
- Low glitch of 4 cycles on an idle line -> FSM returns to IDLE; no valid, no error pulse.
- Send 0x3C with stop bit driven 0, then hold the line low for 100 cycles -> one `rx_frame_err` pulse, no `rx_valid`. After the line goes high, 0x5A is received correctly.
- Assert `sys_reset` during data bit 4 of a frame -> all outputs 0 immediately. The frame is not delivered, and the next full frame 0xC3 is delivered; repeat with `UART_STOP_BITS=2` and confirm the latency shifts by CPB.
